// File: rtl/lmg_move_packer.sv
// lmg_move_packer: packs single legal moves into MPW-slot words with a count
// header and queues them in a show-behind FIFO for the search side.
// Supports backpressure, partial-word flush at end of list and an explicit
// count=0 word for an empty move list.
// Optional build macro: LMG_DROP_INVALID_EN -- accepted moves whose flag is
// 7'h40 are consumed but neither packed nor counted.
module lmg_move_packer #(
    parameter int MOVE_W = 19,
    parameter int MPW    = 8,
    parameter int CNT_W  = 8,
    parameter int DEPTH  = 64,
    parameter int AW     = 6,
    localparam int WORD_W = CNT_W + MPW * MOVE_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mv_valid,
    input  logic [MOVE_W-1:0] mv_data,
    output logic              mv_ready,
    input  logic              gen_done,
    input  logic              rden,
    output logic [WORD_W-1:0] fifoOut,
    output logic              fifoEmpty,
    output logic              fifoFull,
    output logic [AW:0]       fifoUsedw,
    output logic              done
);

    localparam int IW = $clog2(MPW + 1);
    localparam int SW = MPW * MOVE_W;
    localparam logic [MOVE_W-1:0] INVALID_MV = {7'h40, {(MOVE_W-7){1'b0}}};

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DONE} state_t;

    // Slots at or above MPW-k hold moves (first move at the top); the rest are invalid.
    function automatic logic [WORD_W-1:0] pack_word(input logic [SW-1:0] s, input logic [IW-1:0] k);
        logic [SW-1:0] body;
        for (int j = 0; j < MPW; j++)
            body[j*MOVE_W +: MOVE_W] = (j >= MPW - int'(k)) ? s[j*MOVE_W +: MOVE_W] : INVALID_MV;
        return {CNT_W'(k), body};
    endfunction

    state_t            state;
    logic [IW-1:0]     cnt;        // moves in the word under construction
    logic              pend;       // hold holds a finished word awaiting FIFO space
    logic              any_acc;    // at least one move packed in this list
    logic              flushed;    // partial/empty word already loaded in FLUSH
    logic [SW-1:0]     slot_buf;
    logic [SW-1:0]     full_slots;
    logic [WORD_W-1:0] hold;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp, rp;
    logic              drop, take, keep, fill_now, need_flush, flush_load;
    logic              wr_en, rd_en, pend_nxt, fill_nxt, mv_ready_nxt;
    logic [AW:0]       usedw_nxt;

    assign fifoEmpty = (fifoUsedw == '0);
    assign fifoFull  = (fifoUsedw == (AW+1)'(DEPTH));

    // Handshake, commit and FIFO next-state decode; mv_ready is pre-computed from next state.
    always_comb begin
`ifdef LMG_DROP_INVALID_EN
        drop = (mv_data[MOVE_W-1 -: 7] == 7'h40);
`else
        drop = 1'b0;
`endif
        take       = mv_valid && mv_ready && (state == FILL) && !start;
        keep       = take && !drop;
        fill_now   = keep && (cnt == IW'(MPW - 1));
        need_flush = !flushed && ((cnt != '0) || !any_acc);
        flush_load = (state == FLUSH) && !pend && need_flush && !start;
        wr_en      = pend && !fifoFull && !start;
        rd_en      = rden && !fifoEmpty && !start;
        usedw_nxt  = start ? '0 : fifoUsedw + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        if (start)
            pend_nxt = 1'b0;
        else if (fill_now || flush_load)
            pend_nxt = 1'b1;
        else if (wr_en)
            pend_nxt = 1'b0;
        else
            pend_nxt = pend;
        fill_nxt     = start || ((state == FILL) && !gen_done);
        mv_ready_nxt = fill_nxt && !(pend_nxt && (usedw_nxt == (AW+1)'(DEPTH)));
        full_slots   = slot_buf;
        full_slots[MOVE_W-1:0] = mv_data;
    end

    // Control FSM: list state, slot count, pending-word flag and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= 1'b0;
            any_acc  <= 1'b0;
            flushed  <= 1'b0;
            mv_ready <= 1'b0;
            done     <= 1'b0;
        end else begin
            mv_ready <= mv_ready_nxt;
            pend     <= pend_nxt;
            if (start) begin
                state   <= FILL;
                cnt     <= '0;
                any_acc <= 1'b0;
                flushed <= 1'b0;
                done    <= 1'b0;
            end else begin
                case (state)
                    FILL: begin
                        if (keep) begin
                            cnt     <= fill_now ? '0 : cnt + IW'(1);
                            any_acc <= 1'b1;
                        end
                        if (gen_done)
                            state <= FLUSH;
                    end
                    FLUSH: begin
                        if (flush_load)
                            flushed <= 1'b1;
                        else if (!pend && !need_flush) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Move slots and the outgoing word register; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (keep)
            slot_buf[(MPW - 1 - int'(cnt))*MOVE_W +: MOVE_W] <= mv_data;
        if (fill_now)
            hold <= pack_word(full_slots, IW'(MPW));
        else if (flush_load)
            hold <= pack_word(slot_buf, cnt);
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wp] <= hold;
    end

    // FIFO pointers, fill level and show-behind output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp        <= '0;
            rp        <= '0;
            fifoUsedw <= '0;
            fifoOut   <= '0;
        end else begin
            fifoUsedw <= usedw_nxt;
            if (start) begin
                wp <= '0;
                rp <= '0;
            end else begin
                if (wr_en)
                    wp <= wp + AW'(1);
                if (rd_en) begin
                    fifoOut <= mem[rp];
                    rp      <= rp + AW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lmg_move_packer.sv
// tb_lmg_move_packer: directed bench for lmg_move_packer (DEPTH=4 instance).
module tb_lmg_move_packer;

    localparam int WW = 160;
    localparam logic [18:0] INV = {7'h40, 12'd0};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          mv_valid = 1'b0;
    logic [18:0]   mv_data = '0;
    logic          mv_ready;
    logic          gen_done = 1'b0;
    logic          rden = 1'b0;
    logic [WW-1:0] fifoOut;
    logic          fifoEmpty;
    logic          fifoFull;
    logic [2:0]    fifoUsedw;
    logic          done;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [18:0]   exp_mv [0:63];
    logic [WW-1:0] w;

    lmg_move_packer #(.MOVE_W(19), .MPW(8), .CNT_W(8), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mv_valid(mv_valid),
        .mv_data(mv_data), .mv_ready(mv_ready), .gen_done(gen_done), .rden(rden),
        .fifoOut(fifoOut), .fifoEmpty(fifoEmpty), .fifoFull(fifoFull),
        .fifoUsedw(fifoUsedw), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] exp_word(input int cnt, input int base);
        logic [WW-1:0] r;
        r = '0;
        r[159:152] = 8'(cnt);
        for (int j = 0; j < 8; j++)
            r[j*19 +: 19] = (j >= 8 - cnt) ? exp_mv[base + 7 - j] : INV;
        return r;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_move(input logic [18:0] m, input logic last, input string tag);
        logic ok;
        ok = 1'b0;
        mv_valid = 1'b1;
        mv_data  = m;
        gen_done = last;
        for (int i = 0; i < 50; i++) begin
            if (mv_ready) begin
                ok = 1'b1;
                step();
                break;
            end
            step();
        end
        mv_valid = 1'b0;
        gen_done = 1'b0;
        if (!ok)
            check_eq(tag, WW'(1'b0), WW'(1'b1));
    endtask

    task automatic pulse_gen_done;
        gen_done = 1'b1;
        step();
        gen_done = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 50 && !done; i++)
            step();
        check_eq(tag, WW'(done), WW'(1'b1));
    endtask

    task automatic read_word(output logic [WW-1:0] r);
        rden = 1'b1;
        step();
        rden = 1'b0;
        r = fifoOut;
    endtask

    initial begin
        step();
        check_eq("rst_ready", WW'(mv_ready), WW'(1'b0));
        check_eq("rst_done",  WW'(done), WW'(1'b0));
        check_eq("rst_out",   fifoOut, '0);
        check_eq("rst_empty", WW'(fifoEmpty), WW'(1'b1));
        check_eq("rst_full",  WW'(fifoFull), WW'(1'b0));
        check_eq("rst_usedw", WW'(fifoUsedw), WW'(0));
        step();
        reset_n = 1'b1;
        step();
        check_eq("idle_ready", WW'(mv_ready), WW'(1'b0));

        // 1: eight moves -> one full word
        for (int i = 0; i < 8; i++)
            exp_mv[i] = {7'h00, 6'(8*i + 1), 6'(8*i + 2)};
        do_start();
        check_eq("t1_ready", WW'(mv_ready), WW'(1'b1));
        for (int i = 0; i < 8; i++)
            send_move(exp_mv[i], 1'b0, "t1_accept");
        pulse_gen_done();
        wait_done("t1_done");
        check_eq("t1_usedw", WW'(fifoUsedw), WW'(1));
        check_eq("t1_ready_done", WW'(mv_ready), WW'(1'b0));
        read_word(w);
        check_eq("t1_word", w, exp_word(8, 0));
        check_eq("t1_empty", WW'(fifoEmpty), WW'(1'b1));

        // 2: three moves, gen_done with the last
        exp_mv[0] = {7'h02, 6'o10, 6'o20};
        exp_mv[1] = {7'h00, 6'o33, 6'o44};
        exp_mv[2] = {7'h11, 6'o77, 6'o00};
        do_start();
        check_eq("t2_done_clr", WW'(done), WW'(1'b0));
        send_move(exp_mv[0], 1'b0, "t2_accept");
        send_move(exp_mv[1], 1'b0, "t2_accept");
        send_move(exp_mv[2], 1'b1, "t2_accept");
        wait_done("t2_done");
        check_eq("t2_usedw", WW'(fifoUsedw), WW'(1));
        read_word(w);
        check_eq("t2_word", w, exp_word(3, 0));

        // 3: empty list
        do_start();
        pulse_gen_done();
        wait_done("t3_done");
        check_eq("t3_usedw", WW'(fifoUsedw), WW'(1));
        read_word(w);
        check_eq("t3_word", w, {8'd0, {8{INV}}});
        check_eq("t3_empty", WW'(fifoEmpty), WW'(1'b1));

        // 4: backpressure with a 4-word FIFO
        for (int i = 0; i < 40; i++)
            exp_mv[i] = {7'h00, 6'(i), 6'(i + 1)};
        do_start();
        for (int i = 0; i < 40; i++)
            send_move(exp_mv[i], 1'b0, "t4_accept");
        check_eq("t4_full", WW'(fifoFull), WW'(1'b1));
        check_eq("t4_usedw", WW'(fifoUsedw), WW'(4));
        check_eq("t4_stall", WW'(mv_ready), WW'(1'b0));
        step();
        check_eq("t4_stall_hold", WW'(mv_ready), WW'(1'b0));
        read_word(w);
        check_eq("t4_word0", w, exp_word(8, 0));
        begin
            logic ok;
            ok = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (mv_ready) begin
                    ok = 1'b1;
                    break;
                end
                step();
            end
            check_eq("t4_resume", WW'(ok), WW'(1'b1));
        end
        pulse_gen_done();
        wait_done("t4_done");
        check_eq("t4_usedw_end", WW'(fifoUsedw), WW'(4));
        for (int k = 1; k < 5; k++) begin
            read_word(w);
            check_eq($sformatf("t4_word%0d", k), w, exp_word(8, 8*k));
        end
        check_eq("t4_empty", WW'(fifoEmpty), WW'(1'b1));

        // 5: abort with start, then async reset mid-fill
        do_start();
        for (int i = 0; i < 5; i++)
            send_move({7'h00, 6'(i), 6'o70}, 1'b0, "t5_accept");
        do_start();
        check_eq("t5_empty", WW'(fifoEmpty), WW'(1'b1));
        check_eq("t5_usedw", WW'(fifoUsedw), WW'(0));
        check_eq("t5_ready", WW'(mv_ready), WW'(1'b1));
        exp_mv[0] = {7'h05, 6'o21, 6'o43};
        send_move(exp_mv[0], 1'b1, "t5_accept");
        wait_done("t5_done");
        read_word(w);
        check_eq("t5_word", w, exp_word(1, 0));
        do_start();
        for (int i = 0; i < 18; i++)
            send_move({7'h00, 6'(i), 6'(i + 3)}, 1'b0, "t5_accept");
        check_eq("t5_usedw2", WW'(fifoUsedw), WW'(2));
        read_word(w);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("t5_rst_ready", WW'(mv_ready), WW'(1'b0));
        check_eq("t5_rst_out",   fifoOut, '0);
        check_eq("t5_rst_empty", WW'(fifoEmpty), WW'(1'b1));
        check_eq("t5_rst_usedw", WW'(fifoUsedw), WW'(0));
        check_eq("t5_rst_done",  WW'(done), WW'(1'b0));
        step();
        reset_n = 1'b1;
        step();

        // 6: invalid move in the middle
        exp_mv[0] = {7'h00, 6'o12, 6'o34};
        exp_mv[1] = {7'h40, 6'o05, 6'o06};
        exp_mv[2] = {7'h01, 6'o44, 6'o55};
        do_start();
        send_move(exp_mv[0], 1'b0, "t6_accept");
        send_move(exp_mv[1], 1'b0, "t6_accept");
        send_move(exp_mv[2], 1'b1, "t6_accept");
        wait_done("t6_done");
        read_word(w);
`ifdef LMG_DROP_INVALID_EN
        exp_mv[1] = exp_mv[2];
        check_eq("t6_word", w, exp_word(2, 0));
`else
        check_eq("t6_word", w, exp_word(3, 0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
